// File: rtl/event_time_scheduler_pkg.sv
// Shared types and widths for the emulated-time scheduler.
package event_time_scheduler_pkg;

    localparam int TIME_WIDTH    = 12;
    localparam int DT_WIDTH      = 8;
    localparam int SCHED_NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELOAD  = 2'd1,
        ADVANCE = 2'd2
    } sched_state_t;

    typedef logic [TIME_WIDTH-1:0] deadline_format_t;

endpackage

// File: rtl/event_time_scheduler_if.sv
// Requester-side bus of the scheduler: run enable, per-requester loads, time outputs.
interface event_time_scheduler_if
    import event_time_scheduler_pkg::*;
#(
    parameter int N_REQ  = SCHED_NUM_REQ,
    parameter int TIME_W = TIME_WIDTH,
    parameter int DT_W   = DT_WIDTH
);

    logic                   en;
    logic [N_REQ-1:0]       req_load;
    logic [N_REQ*DT_W-1:0]  req_dt;
    logic [N_REQ-1:0]       time_eq;
    logic [TIME_W-1:0]      time_next;
    logic                   stall;
    logic                   ovf_err;

    modport master (
        output en, req_load, req_dt,
        input  time_eq, time_next, stall, ovf_err
    );

    modport slave (
        input  en, req_load, req_dt,
        output time_eq, time_next, stall, ovf_err
    );

endinterface

// File: rtl/event_time_scheduler_min_tree.sv
// Combinational compare tree: earliest pending deadline and the set of requesters due at it.
module time_min_tree #(
    parameter int N_REQ  = 2,
    parameter int TIME_W = 12
) (
    input  logic [N_REQ-1:0][TIME_W-1:0] deadlines,
    input  logic [N_REQ-1:0]             pending,
    output logic [TIME_W-1:0]            min_val,
    output logic [N_REQ-1:0]             due
);

    localparam int LEVELS = (N_REQ > 1) ? $clog2(N_REQ) : 0;
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;

    // Heap-ordered tree: leaves hold deadlines, unused or idle leaves lose every compare.
    logic [TIME_W-1:0] node_val [NODES];
    logic              node_vld [NODES];
    logic              take_left;

    // Reduce leaves to the root one level at a time, then flag every pending requester at the minimum.
    always_comb begin
        take_left = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            node_val[i] = '1;
            node_vld[i] = 1'b0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            node_val[LEAVES-1+i] = deadlines[i];
            node_vld[LEAVES-1+i] = pending[i];
        end
        for (int i = LEAVES - 2; i >= 0; i--) begin
            take_left = node_vld[2*i+1] &&
                        (!node_vld[2*i+2] || (node_val[2*i+1] <= node_val[2*i+2]));
            node_val[i] = take_left ? node_val[2*i+1] : node_val[2*i+2];
            node_vld[i] = node_vld[2*i+1] | node_vld[2*i+2];
        end
        min_val = node_val[0];
        for (int k = 0; k < N_REQ; k++) begin
            due[k] = pending[k] && (deadlines[k] == node_val[0]);
        end
    end

endmodule

// File: rtl/event_time_scheduler.sv
// Earliest-deadline emulated-time scheduler: holds one deadline per requester and
// advances time to the earliest one, strobing every requester due at that time.
module event_time_scheduler
    import event_time_scheduler_pkg::*;
#(
    parameter int N_REQ  = SCHED_NUM_REQ,
    parameter int TIME_W = TIME_WIDTH,
    parameter int DT_W   = DT_WIDTH
) (
    input  logic                   clk_sys,
    input  logic                   rst,
    event_time_scheduler_if.slave  bus
);

    localparam int SUM_W = TIME_W + 1;

    sched_state_t                 state;
    logic [N_REQ-1:0][TIME_W-1:0] deadline;
    logic [N_REQ-1:0][TIME_W-1:0] load_deadline;
    logic [N_REQ-1:0]             pending;
    logic [N_REQ-1:0]             fired;
    logic [N_REQ-1:0]             load_ok;
    logic [N_REQ-1:0]             load_ovf;
    logic [N_REQ-1:0]             due;
    logic [TIME_W-1:0]            min_val;
    logic [SUM_W-1:0]             sum_full [N_REQ];

    logic [TIME_W-1:0]            time_next_q;
    logic [N_REQ-1:0]             time_eq_q;
    logic                         stall_q;
    logic                         ovf_q;

    // Loads are ignored until the scheduler has left IDLE.
    assign load_ok = (state == IDLE) ? '0 : bus.req_load;

    time_min_tree #(
        .N_REQ  (N_REQ),
        .TIME_W (TIME_W)
    ) u_min_tree (
        .deadlines (deadline),
        .pending   (pending),
        .min_val   (min_val),
        .due       (due)
    );

    // New deadline per requester: current time plus delay, saturating at the top of the time range.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            sum_full[k]      = {1'b0, time_next_q} + SUM_W'(bus.req_dt[k*DT_W +: DT_W]);
            load_deadline[k] = sum_full[k][TIME_W] ? '1 : sum_full[k][TIME_W-1:0];
            load_ovf[k]      = load_ok[k] & sum_full[k][TIME_W];
        end
    end

    // FSM with registered outputs; a load in the same cycle overrides that requester's fire.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            time_next_q <= '0;
            time_eq_q   <= '0;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
            pending     <= '0;
            fired       <= '0;
            deadline    <= '0;
        end else begin
            time_eq_q <= '0;
            stall_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) state <= RELOAD;
                end
                RELOAD: begin
                    if (bus.en && (fired == '0) && (pending != '0)) state <= ADVANCE;
                    stall_q <= (fired == '0) && (pending == '0);
                end
                ADVANCE: begin
                    state       <= RELOAD;
                    time_next_q <= min_val;
                    time_eq_q   <= due & ~load_ok;
                    pending     <= pending & ~due;
                    fired       <= due & ~load_ok;
                end
                default: state <= IDLE;
            endcase
            for (int k = 0; k < N_REQ; k++) begin
                if (load_ok[k]) begin
                    deadline[k] <= load_deadline[k];
                    pending[k]  <= 1'b1;
                    fired[k]    <= 1'b0;
                end
            end
            if (|load_ovf) ovf_q <= 1'b1;
        end
    end

    assign bus.time_next = time_next_q;
    assign bus.time_eq   = time_eq_q;
    assign bus.stall     = stall_q;
    assign bus.ovf_err   = ovf_q;

endmodule
